pipeline_stall_controller: RTL

//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges three hazard sources:

---
 rtl/pipeline_stall_controller_pkg.sv | 65 ++++++
 rtl/pipeline_stall_controller_if.sv | 31 +++
 rtl/pipeline_stall_controller_sat_counter.sv | 23 ++
 rtl/pipeline_stall_controller.sv | 114 +++++++++++
 4 files changed

// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and helpers for the pipeline stall/flush sequencer.
// Holds the FSM state encoding and the per-stage control word decode.
package pipeline_stall_controller_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int DEFAULT_CNT_W          = 16;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } stall_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
        logic dmem_start;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RESET = '{
        pc_write:     1'b0,
        if_id_write:  1'b0,
        if_id_flush:  1'b0,
        id_ex_bubble: 1'b0,
        pipe_freeze:  1'b1,
        dmem_start:   1'b0
    };

    // Freeze holds ID, so load_use/branch are ignored and re-evaluated once unfrozen.
    // A branch under load_use is not taken yet because its operands are stale.
    function automatic stage_ctrl_t decode_hazards(input logic freeze,
                                                   input logic load_use,
                                                   input logic branch_taken,
                                                   input logic dmem_start);
        stage_ctrl_t c;
        c = '0;
        c.pipe_freeze = freeze;
        c.dmem_start  = dmem_start;
        if (freeze) begin
            c.pc_write     = 1'b0;
            c.if_id_write  = 1'b0;
            c.id_ex_bubble = 1'b0;
            c.if_id_flush  = 1'b0;
        end else if (load_use) begin
            c.pc_write     = 1'b0;
            c.if_id_write  = 1'b0;
            c.id_ex_bubble = 1'b1;
            c.if_id_flush  = 1'b0;
        end else if (branch_taken) begin
            c.pc_write     = 1'b1;
            c.if_id_write  = 1'b1;
            c.id_ex_bubble = 1'b0;
            c.if_id_flush  = 1'b1;
        end else begin
            c.pc_write     = 1'b1;
            c.if_id_write  = 1'b1;
            c.id_ex_bubble = 1'b0;
            c.if_id_flush  = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-request / stage-control bundle between hazard detection and the stall controller.
// master drives the hazard requests, slave (the controller) drives the stage controls.
interface pipeline_stall_controller_if #(
    parameter int CNT_W = 16
);
    logic             load_use;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             ID_EX_bubble;
    logic             pipe_freeze;
    logic             dmem_start;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output load_use, branch_taken, dmem_req, dmem_ready,
        input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze,
               dmem_start, mem_error, stall_cycles, flush_count
    );

    modport slave (
        input  load_use, branch_taken, dmem_req, dmem_ready,
        output pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, pipe_freeze,
               dmem_start, mem_error, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count qualifying cycles, holding at the maximum value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: merges load-use, taken-branch and data-memory wait
// hazards into one control set, and owns the MEM-wait FSM, its timeout and perf counters.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_stall_controller_if.slave   bus
);

    localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    stall_state_e       state_r;
    logic [TIMER_W-1:0] timer_r;
    logic               mem_error_r;
    logic               freeze_s;
    logic               start_s;
    stage_ctrl_t        ctrl_s;

    // Memory-side freeze and start decode from FSM state and the current handshake
    always_comb begin
        freeze_s = 1'b0;
        start_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                start_s  = bus.dmem_req;
                freeze_s = bus.dmem_req & ~bus.dmem_ready;
            end
            ST_MEM_WAIT: begin
                start_s  = 1'b0;
                freeze_s = ~bus.dmem_ready;
            end
            default: begin
                start_s  = 1'b0;
                freeze_s = 1'b1;
            end
        endcase
    end

    // Whole pipeline stays frozen and quiet while reset is held
    always_comb begin
        ctrl_s = CTRL_RESET;
        if (!rst_n) begin
            ctrl_s = CTRL_RESET;
        end else begin
            ctrl_s = decode_hazards(freeze_s, bus.load_use, bus.branch_taken, start_s);
        end
    end

    assign bus.pc_write     = ctrl_s.pc_write;
    assign bus.IF_ID_write  = ctrl_s.if_id_write;
    assign bus.IF_ID_flush  = ctrl_s.if_id_flush;
    assign bus.ID_EX_bubble = ctrl_s.id_ex_bubble;
    assign bus.pipe_freeze  = ctrl_s.pipe_freeze;
    assign bus.dmem_start   = ctrl_s.dmem_start;
    assign bus.mem_error    = mem_error_r;

    // MEM-wait FSM with timeout; a timed-out access is dropped and flagged until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            timer_r     <= '0;
            mem_error_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (bus.dmem_req && !bus.dmem_ready) begin
                        state_r <= ST_MEM_WAIT;
                        timer_r <= '0;
                    end else begin
                        state_r <= ST_RUN;
                        timer_r <= timer_r;
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ready) begin
                        state_r <= ST_RUN;
                        timer_r <= timer_r;
                    end else if (timer_r == TIMER_LAST) begin
                        state_r     <= ST_RUN;
                        timer_r     <= timer_r;
                        mem_error_r <= 1'b1;
                    end else begin
                        state_r <= ST_MEM_WAIT;
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    timer_r <= '0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl_s.pc_write),
        .count (bus.stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl_s.if_id_flush),
        .count (bus.flush_count)
    );

endmodule
